fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential instruction-memory reads,
// buffers the returned words with their addresses in a small prefetch FIFO
// and hands them to the consumer under a valid/ready handshake. Supports
// halting, redirection to a new fetch address and asynchronous reset.

package pkg_config;
    parameter int INST_WIDTH = 32;
endpackage

module fetch_unit
    import pkg_config::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  halt_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    output logic                  imem_req_o,
    output logic [31:0]           imem_addr_o,
    input  logic [INST_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [INST_WIDTH-1:0] instr_o,
    output logic [31:0]           instr_pc_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HALTED
    } state_e;

    state_e state_q;

    logic [31:0]      fetch_pc_q,    fetch_pc_d;
    logic             inflight_q,    inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;

    logic [INST_WIDTH-1:0] buf_data_q [FIFO_DEPTH];
    logic [31:0]           buf_pc_q   [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic             req;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] occupancy_limit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake, push qualification and request gating.
    always_comb begin
        pop  = (count_q != '0) && instr_ready_i;
        // A response whose request is being squashed by a redirect is dropped.
        push = inflight_q && !redirect_i;
        // Slots already claimed (buffered plus in flight) must stay below the
        // depth once this cycle's pop frees one, so the FIFO cannot overflow.
        occupancy       = OCC_W'(count_q) + OCC_W'(inflight_q);
        occupancy_limit = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);
        req = (state_q == ST_FETCH) && !redirect_i && (occupancy < occupancy_limit);
    end

    // Next-state computation for fetch address, in-flight tracking and FIFO pointers.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves a value unassigned and infers a latch.
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = req;
        inflight_pc_d = fetch_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect_i) begin
            // Flush everything; a coinciding pop is already owned by the consumer.
            fetch_pc_d = redirect_pc_i & ~32'd3;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state FSM: BOOT for exactly one cycle, then FETCH or HALTED following halt_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_BOOT;
        end else begin
            case (state_q)
                ST_BOOT:   state_q <= halt_i ? ST_HALTED : ST_FETCH;
                ST_FETCH:  if (halt_i)  state_q <= ST_HALTED;
                ST_HALTED: if (!halt_i) state_q <= ST_FETCH;
                default:   state_q <= ST_BOOT;
            endcase
        end
    end

    // Datapath control registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Prefetch buffer storage: write the returning word and its address at the tail.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; entries are only visible while count is non-zero and outputs are gated otherwise.
        if (push) begin
            buf_data_q[wr_ptr_q] <= imem_rdata_i;
            buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? buf_data_q[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? buf_pc_q[rd_ptr_q]   : '0;

endmodule
